// File: rtl/usb_cdc_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_cdc_in_arbiter
// Description : Burst-granular round-robin arbiter sharing the usb_cdc IN
//               byte channel among NUM_REQ requesters.
// Revision    : 1.0
// ============================================================================
module usb_cdc_in_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   configured_i,
    input  logic [NUM_REQ-1:0]     req_en_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             in_data_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_XFER  = 1'b1;
    localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_BURST);
    localparam logic [PTR_W-1:0] C_PTR0  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W:0]     w_sum;
    logic [7:0]         w_data;
    logic               w_gvalid;
    logic               w_glast;
    logic               w_pass;
    logic               w_beat;
    logic [CNT_W-1:0]   w_count_nxt;

    assign w_elig = req_valid_i & req_en_i;

    // Round-robin search starting just above the last released requester.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && w_elig[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PTR_W-1:0];
            end
        end
    end

    // AND-OR mux of the granted lane; yields zeros when nothing is granted.
    always_comb begin
        w_data = 8'h00;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (r_grant[n]) begin
                w_data = w_data | req_data_i[8*n +: 8];
            end
        end
    end

    assign w_gvalid    = |(req_valid_i & r_grant);
    assign w_glast     = |(req_last_i & r_grant);
    assign w_pass      = (r_state == S_XFER) && configured_i;
    assign w_beat      = in_valid_o && in_ready_i;
    assign w_count_nxt = r_count + CNT_W'(1);

    assign in_data_o   = w_data;
    assign in_valid_o  = w_pass && w_gvalid;
    assign req_ready_o = (w_pass && in_ready_i) ? r_grant : '0;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state == S_XFER);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= C_PTR0;
            r_count <= '0;
        end else if (r_state == S_IDLE) begin
            if (configured_i && w_found) begin
                r_state <= S_XFER;
                r_grant <= C_ONE << w_sel;
                r_gidx  <= w_sel;
                r_count <= '0;
            end
        end else begin
            // Losing configuration aborts without accepting the current byte.
            if (!configured_i || (w_beat && (w_glast || (w_count_nxt == C_MAX)))) begin
                r_state <= S_IDLE;
                r_grant <= '0;
                r_ptr   <= r_gidx;
                r_count <= '0;
            end else if (w_beat) begin
                r_count <= w_count_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_cdc_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_cdc_in_arbiter
// Description : Self-checking bench for usb_cdc_in_arbiter (table + scoreboard).
// Revision    : 1.0
// ============================================================================
module tb_usb_cdc_in_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 8;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 configured_i;
    logic [NUM_REQ-1:0]   req_en_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           in_data_o;
    logic                 in_valid_o;
    logic                 in_ready_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;

    always #5 clk = ~clk;

    usb_cdc_in_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk), .rst_i(rst_i), .configured_i(configured_i),
        .req_en_i(req_en_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .in_data_o(in_data_o),
        .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .grant_o(grant_o),
        .busy_o(busy_o)
    );

    typedef struct packed { logic [7:0] data; logic last; } src_byte_t;
    typedef struct packed { logic [1:0] idx; logic [7:0] data; } exp_t;
    typedef struct { logic cfg; logic [3:0] en; logic [3:0] valid; logic [3:0] grant; } vec_t;

    src_byte_t src_q[NUM_REQ][$];
    exp_t      exp_q[$];
    int        exp_grant[$];
    int        exp_len[$];
    vec_t      vecs[8];

    int   checks = 0;
    int   fails  = 0;
    int   beats_total;
    int   cur_len;
    logic [NUM_REQ-1:0] prev_grant;
    logic toggle_ready;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
    endtask

    function automatic int idx_of(input logic [NUM_REQ-1:0] g);
        int r = 0;
        for (int n = 0; n < NUM_REQ; n++) if (g[n]) r = n;
        return r;
    endfunction

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) if (src_q[n].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        logic [8*NUM_REQ-1:0] d;
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        d = '0; v = '0; l = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (src_q[n].size() > 0) begin
                v[n]         = 1'b1;
                d[8*n +: 8]  = src_q[n][0].data;
                l[n]         = src_q[n][0].last;
            end
        end
        req_data_i  = d;
        req_valid_i = v;
        req_last_i  = l;
    endtask

    // Mid-cycle observation of the combinational outputs.
    task automatic monitor();
        int g;
        exp_t e;
        check("grant_onehot0", int'($onehot0(grant_o)), 1);
        check("ready_subset_of_grant", int'(req_ready_o & ~grant_o), 0);
        if (!configured_i) check("ready_while_unconfigured", int'(req_ready_o), 0);
        if (prev_grant != 0 && grant_o != prev_grant) begin
            if (exp_len.size() == 0) fail_now("unexpected_burst_end");
            else check("burst_length", cur_len, exp_len.pop_front());
            cur_len = 0;
        end
        if (grant_o != 0 && grant_o != prev_grant) begin
            check("bubble_before_grant", int'(prev_grant), 0);
            if (exp_grant.size() == 0) fail_now("unexpected_grant");
            else check("grant_order", idx_of(grant_o), exp_grant.pop_front());
        end
        if (in_valid_o && in_ready_i && !rst_i) begin
            g = idx_of(grant_o);
            beats_total++;
            cur_len++;
            if (exp_q.size() == 0) fail_now("unexpected_beat");
            else begin
                e = exp_q.pop_front();
                check("beat_requester", g, int'(e.idx));
                check("beat_data", int'(in_data_o), int'(e.data));
                check("beat_ready", int'(req_ready_o[g]), 1);
            end
            if (src_q[g].size() > 0) void'(src_q[g].pop_front());
        end
        prev_grant = grant_o;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (toggle_ready) in_ready_i = ~in_ready_i;
        drive();
    endtask

    task automatic load(input int n, input int start, input int len, input int last_at);
        for (int k = 0; k < len; k++) begin
            src_q[n].push_back({8'(start + k), (k == last_at)});
        end
    endtask

    task automatic expect_bytes(input int n, input int start, input int len);
        for (int k = 0; k < len; k++) exp_q.push_back({2'(n), 8'(start + k)});
    endtask

    task automatic run_until_idle(input string name);
        int n = 0;
        while ((any_pending() || grant_o != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) fail_now({name, "_timeout"});
        tick();
        tick();
        check({name, "_leftover_bytes"}, exp_q.size(), 0);
        check({name, "_leftover_grants"}, exp_grant.size(), 0);
        check({name, "_leftover_lengths"}, exp_len.size(), 0);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        configured_i = 1'b1;
        req_en_i     = '1;
        req_data_i   = '0;
        req_valid_i  = '0;
        req_last_i   = '0;
        in_ready_i   = 1'b1;
        toggle_ready = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) src_q[n].delete();
        exp_q.delete();
        exp_grant.delete();
        exp_len.delete();
        prev_grant  = '0;
        cur_len     = 0;
        beats_total = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", int'(grant_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_in_valid", int'(in_valid_o), 0);
        check("reset_in_data", int'(in_data_o), 0);
        check("reset_req_ready", int'(req_ready_o), 0);
        rst_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Arbitration decisions straight out of reset (pointer at NUM_REQ-1).
        vecs[0] = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
        vecs[1] = '{1'b1, 4'b1111, 4'b1100, 4'b0100};
        vecs[2] = '{1'b1, 4'b1101, 4'b1010, 4'b1000};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 4'b0000};
        vecs[4] = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[5] = '{1'b1, 4'b0000, 4'b1111, 4'b0000};
        vecs[6] = '{1'b1, 4'b1111, 4'b1000, 4'b1000};
        vecs[7] = '{1'b1, 4'b1110, 4'b0011, 4'b0010};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            configured_i = vecs[i].cfg;
            req_en_i     = vecs[i].en;
            req_valid_i  = vecs[i].valid;
            @(posedge clk);
            #1;
            check("table_grant", int'(grant_o), int'(vecs[i].grant));
            check("table_busy", int'(busy_o), int'(|vecs[i].grant));
            req_valid_i = '0;
        end

        // Single three-byte burst from requester 0.
        do_reset();
        src_q[0].push_back({8'h11, 1'b0});
        src_q[0].push_back({8'h22, 1'b0});
        src_q[0].push_back({8'h33, 1'b1});
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd0, 8'h22});
        exp_q.push_back({2'd0, 8'h33});
        exp_grant.push_back(0);
        exp_len.push_back(3);
        drive();
        tick();
        check("first_grant_latency", int'(grant_o), 4'b0001);
        check("first_grant_busy", int'(busy_o), 1);
        run_until_idle("single_burst");

        // All requesters contending with two-byte bursts.
        do_reset();
        load(0, 8'hA0, 2, 1);
        load(0, 8'hA2, 2, 1);
        load(1, 8'hB0, 2, 1);
        load(2, 8'hC0, 2, 1);
        load(3, 8'hD0, 2, 1);
        expect_bytes(0, 8'hA0, 2);
        expect_bytes(1, 8'hB0, 2);
        expect_bytes(2, 8'hC0, 2);
        expect_bytes(3, 8'hD0, 2);
        expect_bytes(0, 8'hA2, 2);
        exp_grant = '{0, 1, 2, 3, 0};
        exp_len   = '{2, 2, 2, 2, 2};
        drive();
        run_until_idle("round_robin");

        // Long stream from a lone requester is cut at MAX_BURST.
        do_reset();
        load(2, 8'h40, 20, 19);
        expect_bytes(2, 8'h40, 20);
        exp_grant = '{2, 2, 2};
        exp_len   = '{8, 8, 4};
        drive();
        run_until_idle("max_burst_alone");

        // After a MAX_BURST cut, a waiting requester wins next.
        do_reset();
        load(2, 8'h60, 10, 9);
        expect_bytes(2, 8'h60, 8);
        expect_bytes(0, 8'h80, 2);
        exp_q.push_back({2'd2, 8'h68});
        exp_q.push_back({2'd2, 8'h69});
        exp_grant = '{2, 0, 2};
        exp_len   = '{8, 2, 2};
        drive();
        tick();
        load(0, 8'h80, 2, 1);
        drive();
        run_until_idle("max_burst_contended");

        // Backpressure: beats, and the burst count, advance only on ready.
        do_reset();
        toggle_ready = 1'b1;
        load(1, 8'hA0, 9, 8);
        expect_bytes(1, 8'hA0, 9);
        exp_grant = '{1, 1};
        exp_len   = '{8, 1};
        drive();
        run_until_idle("backpressure");
        toggle_ready = 1'b0;
        in_ready_i   = 1'b1;

        // Configuration lost after three beats aborts the burst.
        do_reset();
        load(0, 8'hC0, 6, 5);
        expect_bytes(0, 8'hC0, 6);
        exp_grant = '{0, 0};
        exp_len   = '{3, 3};
        drive();
        n = 0;
        while (beats_total < 3 && n < 50) begin
            tick();
            n++;
        end
        check("abort_reached_three_beats", beats_total, 3);
        configured_i = 1'b0;
        tick();
        check("abort_grant_cleared", int'(grant_o), 0);
        check("abort_busy_cleared", int'(busy_o), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_grant_unconfigured", int'(grant_o), 0);
        end
        configured_i = 1'b1;
        run_until_idle("abort_resume");

        // Reset in the middle of a burst; arbitration restarts at requester 0.
        do_reset();
        load(2, 8'h50, 6, 5);
        expect_bytes(2, 8'h50, 6);
        exp_grant.push_back(2);
        exp_len.push_back(2);
        drive();
        n = 0;
        while (beats_total < 2 && n < 50) begin
            tick();
            n++;
        end
        check("midreset_reached_two_beats", beats_total, 2);
        rst_i = 1'b1;
        tick();
        check("midreset_grant", int'(grant_o), 0);
        check("midreset_busy", int'(busy_o), 0);
        check("midreset_in_valid", int'(in_valid_o), 0);
        check("midreset_in_data", int'(in_data_o), 0);
        check("midreset_req_ready", int'(req_ready_o), 0);
        rst_i = 1'b0;
        src_q[2].delete();
        exp_q.delete();
        load(1, 8'hE1, 1, 0);
        load(3, 8'hE3, 1, 0);
        load(0, 8'hE0, 1, 0);
        expect_bytes(0, 8'hE0, 1);
        expect_bytes(1, 8'hE1, 1);
        expect_bytes(3, 8'hE3, 1);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        exp_len.push_back(1);
        exp_len.push_back(1);
        exp_len.push_back(1);
        drive();
        run_until_idle("after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
